// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one MAR/memory path between the instruction
// fetch port (read-only) and the data memory port (read/write). Requests are
// arbitrated round-robin, the MAR is loaded, and the memory cycle then runs
// for WAIT_STATES+1 cycles before the winner is acked.
//
//   state  | meaning
//   IDLE   | no access in flight; requests are arbitrated here
//   LOAD   | MAR loaded with the winner's address
//   ACCESS | MAR driven and memory strobe held for WAIT_STATES+1 cycles
//   DONE   | winner's ack pulsed, read data already captured
module mem_access_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mar_in_en,
  output logic              mar_out_en,
  output logic [ADDR_W-1:0] mar_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              last_dm;
  logic              owner_dm;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pick_dm;

  // DM wins when it asks alone, or on a tie when IF held the last grant
  assign pick_dm = dm_req && (!if_req || !last_dm);

  // Sequencer: state, latched request and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      last_dm    <= 1'b1;
      owner_dm   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mar_in_en  <= 1'b0;
      mar_out_en <= 1'b0;
      mar_data   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            owner_dm  <= pick_dm;
            last_dm   <= pick_dm;
            we_q      <= pick_dm && dm_we;
            addr_q    <= pick_dm ? dm_addr : if_addr;
            wdata_q   <= (pick_dm && dm_we) ? dm_wdata : '0;
            state     <= LOAD;
            mar_in_en <= 1'b1;
            mar_data  <= pick_dm ? dm_addr : if_addr;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          state      <= ACCESS;
          wait_cnt   <= '0;
          mar_in_en  <= 1'b0;
          mar_data   <= '0;
          mar_out_en <= 1'b1;
          mem_rd     <= !we_q;
          mem_wr     <= we_q;
          mem_wdata  <= wdata_q;
        end
        ACCESS: begin
          if (wait_cnt == WAIT_LAST) begin
            state      <= DONE;
            mar_out_en <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
            if_ack     <= !owner_dm;
            dm_ack     <= owner_dm;
            if (!we_q && owner_dm)  dm_rdata <= mem_rdata;
            if (!we_q && !owner_dm) if_rdata <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
